// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Opcodes and rstatus codes are consumed by the execute stage and writeback logic.
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam logic [4:0]  ALU_OP_MUL      = 5'b00110;
    localparam logic [4:0]  ALU_OP_DIV      = 5'b00111;
    localparam logic [31:0] RSTATUS_MUL_EXC = 32'd4;
    localparam logic [31:0] RSTATUS_DIV_EXC = 32'd5;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_t;

    // Radix-4 Booth digit from {b[2i+1], b[2i], b[2i-1]}
    function automatic booth_t booth_dec(input logic [2:0] grp);
        booth_t d;
        d.neg = grp[2] & ~(grp[1] & grp[0]);
        d.one = grp[1] ^ grp[0];
        d.two = (grp == 3'b011) || (grp == 3'b100);
        return d;
    endfunction

endpackage

// File: rtl/mdiv_divstep.sv
// One restoring-divide iteration: shift {rem, quo} left, trial-subtract the
// divisor, keep the difference and set the quotient bit when it does not go negative.
module mdiv_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0]   w_sh;
    logic [WIDTH+1:0] w_diff;
    logic             w_ge;

    assign w_sh   = {i_rem, i_quo[WIDTH-1]};
    assign w_diff = {1'b0, w_sh} - {2'b00, i_dvs};
    assign w_ge   = ~w_diff[WIDTH+1];
    assign o_rem  = w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
    assign o_quo  = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/multdiv_seq.sv
// Iterative multiply (radix-4 Booth) / divide (restoring on magnitudes) unit
// with start/ready handshake, signed/unsigned mode, tag passthrough and flush.
//
// state | meaning
// IDLE  | waiting for exactly one of ctrl_MULT / ctrl_DIV
// RUN   | one Booth or divide iteration per clock, counter counts down to 1
// FIX   | apply sign / exceptions, register outputs, pulse data_resultRDY
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_unsigned,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [TAG_W-1:0] tag_in,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);

    localparam int AW    = 2 * WIDTH + 2;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             r_state, w_state_nx;
    logic [CNT_W-1:0]   r_cnt;
    logic [AW-1:0]      r_acc;
    logic [WIDTH-1:0]   r_a, r_b, r_result;
    logic [TAG_W-1:0]   r_tag, r_tag_out;
    logic               r_prev, r_div, r_uns, r_neg, r_div0, r_ovf, r_exc, r_rdy;

    logic               w_start;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_rem_nx, w_quo_nx, w_quo, w_div_res;
    logic [WIDTH+2:0]   w_m, w_pp, w_hi, w_sum;
    logic [AW-1:0]      w_booth_nx;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_mul_exc;
    booth_t             w_bd;

    assign w_start = (ctrl_MULT ^ ctrl_DIV) & ~flush;
    assign w_abs_a = (~ctrl_unsigned & data_operandA[WIDTH-1]) ? -data_operandA : data_operandA;
    assign w_abs_b = (~ctrl_unsigned & data_operandB[WIDTH-1]) ? -data_operandB : data_operandB;

    // Booth step: add digit * multiplicand to the high part, then arithmetic shift by 2
    assign w_m  = r_uns ? {3'b000, r_a} : {{3{r_a[WIDTH-1]}}, r_a};
    assign w_bd = booth_dec({r_acc[1:0], r_prev});
    always_comb begin
        w_pp = '0;
        if (w_bd.two)      w_pp = w_m << 1;
        else if (w_bd.one) w_pp = w_m;
        if (w_bd.neg)      w_pp = -w_pp;
    end
    assign w_hi       = {r_acc[AW-1], r_acc[AW-1:WIDTH]};
    assign w_sum      = w_hi + w_pp;
    assign w_booth_nx = {w_sum[WIDTH+2], w_sum, r_acc[WIDTH-1:2]};

    // Booth treats the multiplier as signed; unsigned mode adds back A << WIDTH when its MSB is set
    assign w_prod = r_acc[2*WIDTH-1:0]
                  + ((r_uns & r_b[WIDTH-1]) ? {r_a, {WIDTH{1'b0}}} : '0);
    assign w_mul_exc = r_uns ? (|w_prod[2*WIDTH-1:WIDTH])
                             : ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));

    assign w_quo     = r_acc[WIDTH-1:0];
    assign w_div_res = r_div0 ? '0 : (r_neg ? -w_quo : w_quo);

    mdiv_divstep #(.WIDTH(WIDTH)) u_divstep (
        .i_rem (r_acc[2*WIDTH-1:WIDTH]),
        .i_quo (r_acc[WIDTH-1:0]),
        .i_dvs (r_b),
        .o_rem (w_rem_nx),
        .o_quo (w_quo_nx)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nx = ST_RUN;
            ST_RUN:  if (flush) w_state_nx = ST_IDLE;
                     else if (r_cnt == CNT_W'(1)) w_state_nx = ST_FIX;
            ST_FIX:  w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_tag     <= '0;
            r_prev    <= 1'b0;
            r_div     <= 1'b0;
            r_uns     <= 1'b0;
            r_neg     <= 1'b0;
            r_div0    <= 1'b0;
            r_ovf     <= 1'b0;
            r_result  <= '0;
            r_exc     <= 1'b0;
            r_tag_out <= '0;
            r_rdy     <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (flush) begin
                r_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: if (w_start) begin
                        r_div  <= ctrl_DIV;
                        r_uns  <= ctrl_unsigned;
                        r_tag  <= tag_in;
                        r_prev <= 1'b0;
                        r_a    <= data_operandA;
                        r_neg  <= ~ctrl_unsigned & (data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1]);
                        r_div0 <= (data_operandB == '0);
                        r_ovf  <= ~ctrl_unsigned & (data_operandA == {1'b1, {(WIDTH-1){1'b0}}})
                                  & (&data_operandB);
                        r_cnt  <= ctrl_DIV ? CNT_W'(WIDTH) : CNT_W'(WIDTH / 2);
                        r_b    <= ctrl_DIV ? w_abs_b : data_operandB;
                        r_acc  <= {{(WIDTH+2){1'b0}}, ctrl_DIV ? w_abs_a : data_operandB};
                    end
                    ST_RUN: begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_div) begin
                            r_acc <= {2'b00, w_rem_nx, w_quo_nx};
                        end else begin
                            r_acc  <= w_booth_nx;
                            r_prev <= r_acc[1];
                        end
                    end
                    ST_FIX: begin
                        r_result  <= r_div ? w_div_res : w_prod[WIDTH-1:0];
                        r_exc     <= r_div ? (r_div0 | r_ovf) : w_mul_exc;
                        r_tag_out <= r_tag;
                        r_rdy     <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign tag_out        = r_tag_out;

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq at WIDTH=32: scoreboard of expected
// results checked whenever data_resultRDY pulses, plus timing and control checks.
module tb_multdiv_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0, ctrl_unsigned = 1'b0, flush = 1'b0;
    logic [31:0] data_operandA = '0, data_operandB = '0;
    logic [4:0]  tag_in = '0;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;
    logic [4:0]  tag_out;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic [4:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    multdiv_seq #(.WIDTH(32), .TAG_W(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .ctrl_unsigned  (ctrl_unsigned),
        .flush          (flush),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .tag_in         (tag_in),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .tag_out        (tag_out),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    function automatic exp_t model(input bit mul, input bit uns, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] tag);
        exp_t        e;
        longint      p;
        logic [63:0] pu;
        longint      maxv = 64'sd2147483647;
        longint      minv = -64'sd2147483648;
        e.tag = tag;
        if (mul) begin
            if (uns) begin
                pu    = {32'h0, a} * {32'h0, b};
                e.res = pu[31:0];
                e.exc = (pu[63:32] != 32'h0);
            end else begin
                p     = longint'($signed(a)) * longint'($signed(b));
                e.res = p[31:0];
                e.exc = (p > maxv) || (p < minv);
            end
        end else if (b == 32'h0) begin
            e.res = 32'h0;
            e.exc = 1'b1;
        end else if (uns) begin
            e.res = a / b;
            e.exc = 1'b0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b1;
        end else begin
            p     = longint'($signed(a)) / longint'($signed(b));
            e.res = p[31:0];
            e.exc = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clock) begin
        if (data_resultRDY === 1'b1) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ready: result=%h tag=%0d, no operation outstanding",
                         data_result, tag_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (data_result !== e.res) begin
                    n_fail++;
                    $display("FAIL result: got %h expected %h (tag %0d)", data_result, e.res, e.tag);
                end
                n_chk++;
                if (data_exception !== e.exc) begin
                    n_fail++;
                    $display("FAIL exception: got %b expected %b (tag %0d)", data_exception, e.exc, e.tag);
                end
                n_chk++;
                if (tag_out !== e.tag) begin
                    n_fail++;
                    $display("FAIL tag_out: got %0d expected %0d", tag_out, e.tag);
                end
            end
        end
    end

    // Call between edges; the start is sampled at the next rising edge (E0)
    task automatic start_op(input bit mul, input bit uns, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] tag);
        ctrl_MULT     = mul;
        ctrl_DIV      = !mul;
        ctrl_unsigned = uns;
        data_operandA = a;
        data_operandB = b;
        tag_in        = tag;
        sb.push_back(model(mul, uns, a, b, tag));
        @(posedge clock);
        #1;
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: got %b expected 1", busy);
        end
        n_chk++;
        if (data_resultRDY !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_width: got %b expected 0 one cycle after pulse/start", data_resultRDY);
        end
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        ctrl_unsigned = $urandom_range(0, 1);
        data_operandA = $urandom();
        data_operandB = $urandom();
        tag_in        = 5'($urandom());
    endtask

    // Returns #1 after the edge that raised ready, so a start driven now is back-to-back
    task automatic wait_ready(input int n_exp);
        int k;
        bit got;
        k = 0;
        got = 0;
        while (!got && k < 100) begin
            @(posedge clock);
            #1;
            k++;
            if (data_resultRDY === 1'b1) got = 1;
        end
        n_chk++;
        if (!got || k != n_exp) begin
            n_fail++;
            $display("FAIL latency: ready after %0d edges (seen=%0d), expected %0d", k, got, n_exp);
        end
        if (got) begin
            n_chk++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_in_ready_cycle: got %b expected 0", busy);
            end
        end
    endtask

    task automatic run_op(input bit mul, input bit uns, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag);
        @(negedge clock);
        start_op(mul, uns, a, b, tag);
        wait_ready(mul ? 17 : 33);
    endtask

    task automatic check_outputs_zero(input string name);
        n_chk++;
        if (data_result !== 32'h0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 ||
            tag_out !== 5'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: result=%h exc=%b rdy=%b tag=%0d busy=%b, expected all 0",
                     name, data_result, data_exception, data_resultRDY, tag_out, busy);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clock);
        #1;
        check_outputs_zero("reset_state");
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_mult;
        run_op(1, 0, 32'd7, -32'sd3, 5'd4);
        run_op(1, 0, 32'h0001_0000, 32'h0001_0000, 5'd1);
        run_op(1, 1, 32'hFFFF_FFFF, 32'd2, 5'd2);
        run_op(1, 0, -32'sd5, -32'sd9, 5'd3);
        run_op(1, 0, 32'h7FFF_FFFF, 32'd2, 5'd5);
        run_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
        run_op(1, 0, 32'hFFFF_0000, 32'h0000_8000, 5'd7);
        run_op(1, 1, 32'h8000_0001, 32'h8000_0000, 5'd8);
        run_op(1, 1, 32'h0000_FFFF, 32'h0001_0001, 5'd9);
        for (int i = 0; i < 6; i++)
            run_op(1, i[0], $urandom() >> $urandom_range(0, 31), $urandom(), 5'(i + 10));
    endtask

    task automatic test_div;
        run_op(0, 0, -32'sd100, 32'd7, 5'd11);
        run_op(0, 0, 32'd5, 32'd0, 5'd12);
        run_op(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
        run_op(0, 0, 32'd100, -32'sd7, 5'd15);
        run_op(0, 0, -32'sd7, 32'd100, 5'd16);
        run_op(0, 0, -32'sd81, -32'sd9, 5'd17);
        run_op(0, 1, 32'hFFFF_FFFF, 32'd3, 5'd18);
        run_op(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd19);
        for (int i = 0; i < 6; i++)
            run_op(0, i[0], $urandom(), $urandom() >> $urandom_range(0, 31), 5'(i + 20));
    endtask

    task automatic test_busy_ignore;
        // both starts high: no capture
        @(negedge clock);
        ctrl_MULT = 1'b1;
        ctrl_DIV  = 1'b1;
        @(posedge clock);
        #1;
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL both_starts: busy=%b expected 0", busy);
        end
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        // starts during RUN are ignored
        start_op(1, 0, 32'd7, -32'sd3, 5'd4);
        repeat (4) @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd1000;
        data_operandB = 32'd10;
        repeat (2) @(negedge clock);
        ctrl_DIV = 1'b0;
        wait_ready(11);
        // output hold after the pulse
        repeat (3) @(posedge clock);
        #1;
        n_chk++;
        if (data_result !== 32'hFFFF_FFEB || data_exception !== 1'b0 || tag_out !== 5'd4 ||
            busy !== 1'b0) begin
            n_fail++;
            $display("FAIL output_hold: result=%h exc=%b tag=%0d busy=%b, expected ffffffeb 0 4 0",
                     data_result, data_exception, tag_out, busy);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clock);
        start_op(1, 0, 32'd123, 32'd456, 5'd1);
        wait_ready(17);
        start_op(0, 0, -32'sd1000, 32'd33, 5'd2);
        wait_ready(33);
        start_op(0, 1, 32'hDEAD_BEEF, 32'd77, 5'd3);
        wait_ready(33);
        start_op(1, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd31);
        wait_ready(17);
    endtask

    task automatic test_flush;
        @(negedge clock);
        start_op(0, 0, -32'sd100, 32'd7, 5'd9);
        repeat (9) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_flush: got %b expected 0", busy);
        end
        void'(sb.pop_back());
        @(negedge clock);
        flush = 1'b0;
        start_op(1, 0, 32'd6, 32'd6, 5'd3);
        wait_ready(17);
        // flush beats start in the same cycle
        @(negedge clock);
        flush     = 1'b1;
        ctrl_MULT = 1'b1;
        @(posedge clock);
        #1;
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_priority: busy=%b expected 0", busy);
        end
        @(negedge clock);
        flush     = 1'b0;
        ctrl_MULT = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clock);
        start_op(0, 0, -32'sd100, 32'd7, 5'd9);
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_outputs_zero("reset_mid_op");
        void'(sb.pop_back());
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        check_outputs_zero("after_reset_mid_op");
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_busy_ignore;
        test_back_to_back;
        test_flush;
        test_reset_mid;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL outstanding: %0d results never returned, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
